lfsr_sync_checker: RTL

LFSR_SYNC_CHECKER -- requirements
Module: lfsr_sync_checker

---
 rtl/lfsr_sync_checker_if.sv | 24 ++
 rtl/lfsr_sync_checker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_sync_checker_if.sv
// Symbol-stream bundle for lfsr_sync_checker: enable-qualified 16-QAM input plus lock/measurement status.
// clk_en qualifies sym_in on each rising clk edge (valid only, no ready: the checker never stalls).
interface lfsr_sync_checker_if #(
  parameter int MEAS_LOG2 = 20
);
  logic                 clk_en;
  logic [3:0]           sym_in;
  logic [1:0]           lock_state;
  logic                 locked;
  logic                 sym_err;
  logic [MEAS_LOG2:0]   sym_err_cnt;
  logic [MEAS_LOG2+2:0] bit_err_cnt;
  logic                 meas_valid;

  modport master (
    output clk_en, sym_in,
    input  lock_state, locked, sym_err, sym_err_cnt, bit_err_cnt, meas_valid
  );

  modport slave (
    input  clk_en, sym_in,
    output lock_state, locked, sym_err, sym_err_cnt, bit_err_cnt, meas_valid
  );
endinterface

// File: rtl/lfsr_sync_checker.sv
// 22-bit Fibonacci LFSR sync checker: SEARCH/VERIFY/LOCKED acquisition, loss-of-lock and error measurement.
// Optional macro LFSR_CHECK_BIT_ERR_EN enables the bit-error popcount path and bit_err_cnt.
module lfsr_sync_checker #(
  parameter int VERIFY_LEN  = 16,
  parameter int LOSS_WIN    = 64,
  parameter int LOSS_THRESH = 8,
  parameter int MEAS_LOG2   = 20
) (
  input  logic               clk,
  input  logic               reset,
  lfsr_sync_checker_if.slave sif
);
  localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);
  localparam int MW = $clog2(VERIFY_LEN + 1);
  localparam int SW = MEAS_LOG2 + 1;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]           r_state;
  logic                 r_locked;
  logic                 r_sym_err;
  logic                 r_meas_valid;
  logic [21:0]          r_shadow;
  logic [21:0]          r_lfsr;
  logic [4:0]           r_fill;
  logic [MW-1:0]        r_match;
  logic [WW-1:0]        r_win_cnt;
  logic [EW-1:0]        r_win_err;
  logic [MEAS_LOG2-1:0] r_meas_cnt;
  logic [SW-1:0]        r_run_sym;
  logic [SW-1:0]        r_lat_sym;

  logic [21:0]   w_shadow_nxt;
  logic [21:0]   w_lfsr_nxt;
  logic [3:0]    w_diff;
  logic          w_err;
  logic [EW-1:0] w_win_err_nxt;
  logic          w_locked_en;
  logic          w_loss;
  logic          w_win_wrap;
  logic          w_meas_latch;

  assign w_shadow_nxt  = {r_shadow[20:0], sif.sym_in[0]};
  assign w_lfsr_nxt    = {r_lfsr[20:0], r_lfsr[21] ^ r_lfsr[20]};
  assign w_diff        = w_lfsr_nxt[3:0] ^ sif.sym_in;
  assign w_err         = |w_diff;
  assign w_win_err_nxt = r_win_err + EW'(w_err);
  assign w_locked_en   = sif.clk_en && (r_state == ST_LOCKED);
  assign w_loss        = w_locked_en && (w_win_err_nxt >= EW'(LOSS_THRESH));
  assign w_win_wrap    = (r_win_cnt == WW'(LOSS_WIN - 1));
  // Losing lock wins over a coincident measurement wrap: nothing is latched then.
  assign w_meas_latch  = w_locked_en && !w_loss && (&r_meas_cnt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_SEARCH;
      r_locked     <= 1'b0;
      r_sym_err    <= 1'b0;
      r_meas_valid <= 1'b0;
      r_shadow     <= '0;
      r_lfsr       <= '0;
      r_fill       <= '0;
      r_match      <= '0;
      r_win_cnt    <= '0;
      r_win_err    <= '0;
      r_meas_cnt   <= '0;
    end else begin
      r_meas_valid <= w_meas_latch;
      if (sif.clk_en) begin
        case (r_state)
          ST_SEARCH: begin
            r_sym_err <= 1'b0;
            r_shadow  <= w_shadow_nxt;
            if (r_fill == 5'd21) begin
              r_fill <= '0;
              if (|w_shadow_nxt) begin
                r_lfsr  <= w_shadow_nxt;
                r_match <= '0;
                r_state <= ST_VERIFY;
              end
            end else begin
              r_fill <= r_fill + 5'd1;
            end
          end
          ST_VERIFY: begin
            r_sym_err <= 1'b0;
            r_lfsr    <= w_lfsr_nxt;
            if (w_err) begin
              r_state <= ST_SEARCH;
              r_fill  <= '0;
              r_match <= '0;
            end else if (r_match == MW'(VERIFY_LEN - 1)) begin
              r_match  <= '0;
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_match <= r_match + MW'(1);
            end
          end
          ST_LOCKED: begin
            r_lfsr    <= w_lfsr_nxt;
            r_sym_err <= w_err;
            if (w_loss) begin
              r_state    <= ST_SEARCH;
              r_locked   <= 1'b0;
              r_fill     <= '0;
              r_match    <= '0;
              r_win_cnt  <= '0;
              r_win_err  <= '0;
              r_meas_cnt <= '0;
            end else begin
              r_win_cnt  <= w_win_wrap ? '0 : r_win_cnt + WW'(1);
              r_win_err  <= w_win_wrap ? '0 : w_win_err_nxt;
              r_meas_cnt <= r_meas_cnt + MEAS_LOG2'(1);
            end
          end
          default: begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_run_sym <= '0;
      r_lat_sym <= '0;
    end else if (w_loss) begin
      r_run_sym <= '0;
    end else if (w_meas_latch) begin
      r_lat_sym <= r_run_sym + SW'(w_err);
      r_run_sym <= '0;
    end else if (w_locked_en) begin
      r_run_sym <= r_run_sym + SW'(w_err);
    end
  end

`ifdef LFSR_CHECK_BIT_ERR_EN
  localparam int BW = MEAS_LOG2 + 3;
  logic [2:0]    w_pop;
  logic [BW-1:0] r_run_bit;
  logic [BW-1:0] r_lat_bit;

  assign w_pop = {2'b00, w_diff[0]} + {2'b00, w_diff[1]} + {2'b00, w_diff[2]} + {2'b00, w_diff[3]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_run_bit <= '0;
      r_lat_bit <= '0;
    end else if (w_loss) begin
      r_run_bit <= '0;
    end else if (w_meas_latch) begin
      r_lat_bit <= r_run_bit + BW'(w_pop);
      r_run_bit <= '0;
    end else if (w_locked_en) begin
      r_run_bit <= r_run_bit + BW'(w_pop);
    end
  end

  assign sif.bit_err_cnt = r_lat_bit;
`else
  assign sif.bit_err_cnt = '0;
`endif

  assign sif.lock_state  = r_state;
  assign sif.locked      = r_locked;
  assign sif.sym_err     = r_sym_err;
  assign sif.sym_err_cnt = r_lat_sym;
  assign sif.meas_valid  = r_meas_valid;
endmodule
